// File: rtl/pmem_write_buffer.sv
// Write buffer between the L2 downstream port and physical memory.
// Victim lines are queued in a small circular FIFO, coalesced on re-write and drained when the port is idle.
module pmem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_read,
  input  logic         up_write,
  input  logic [31:0]  up_address,
  input  logic [255:0] up_wdata,
  output logic [255:0] up_rdata,
  output logic         up_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RESP, RD_MEM, WR_MEM} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q;
  logic [26:0]        tag_q  [DEPTH];
  logic [255:0]       data_q [DEPTH];
  logic [255:0]       rdata_q, rdata_d;

  logic               ent_we;
  logic [PTR_W-1:0]   ent_idx;
  logic               head_clr;
  logic               hit;
  logic [PTR_W-1:0]   hit_idx;
  logic               full;

  // At most one valid entry can hold a tag, so the last match is the only match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == up_address[31:5])) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  assign full = (count_q == CNT_W'(DEPTH));

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    rdata_d      = rdata_q;
    ent_we       = 1'b0;
    ent_idx      = tail_q;
    head_clr     = 1'b0;
    up_resp      = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;

    unique case (state_q)
      IDLE: begin
        if (up_write) begin
          if (hit) begin
            ent_we  = 1'b1;
            ent_idx = hit_idx;
            state_d = RESP;
          end else if (!full) begin
            ent_we  = 1'b1;
            ent_idx = tail_q;
            tail_d  = tail_q + PTR_W'(1);
            count_d = count_q + CNT_W'(1);
            state_d = RESP;
          end else begin
            state_d = WR_MEM;
          end
        end else if (up_read) begin
          if (hit) begin
            rdata_d = data_q[hit_idx];
            state_d = RESP;
          end else begin
            state_d = RD_MEM;
          end
        end else if (count_q != '0) begin
          state_d = WR_MEM;
        end
      end

      RESP: begin
        up_resp = 1'b1;
        state_d = IDLE;
      end

      RD_MEM: begin
        pmem_read    = 1'b1;
        pmem_address = {up_address[31:5], 5'b0};
        if (pmem_resp) begin
          rdata_d = pmem_rdata;
          state_d = RESP;
        end
      end

      WR_MEM: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[head_q], 5'b0};
        if (pmem_resp) begin
          head_clr = 1'b1;
          head_d   = head_q + PTR_W'(1);
          count_d  = count_q - CNT_W'(1);
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign up_rdata   = rdata_q;
  assign pmem_wdata = data_q[head_q];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      if (ent_we)   valid_q[ent_idx] <= 1'b1;
      if (head_clr) valid_q[head_q]  <= 1'b0;
    end
  end

  // NOTE: tag/data storage is not reset; the valid bits alone decide whether an entry means anything.
  always_ff @(posedge clk) begin
    if (ent_we) begin
      tag_q[ent_idx]  <= up_address[31:5];
      data_q[ent_idx] <= up_wdata;
    end
  end

endmodule
